// File: rtl/div_rr_scheduler_pkg.sv
// Shared definitions for the round-robin divider scheduler: FSM states and
// response error codes.
package div_rr_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    BUSY,
    RESP,
    CLEAR
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_DZ  = 2'b01,
    ERR_TMO = 2'b10
  } err_e;

endpackage

// File: rtl/div_rr_scheduler_arb.sv
// Combinational round-robin arbiter: picks the first set request at or above
// ptr, wrapping modulo N, and returns it one-hot and encoded.
module rr_arbiter_n #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  localparam logic [IDW:0] NV = (IDW+1)'(N);

  logic [2*N-1:0] rot;
  logic [IDW:0]   sum;

  // Rotate so bit 0 is the requester at ptr; the first set bit is then the winner.
  always_comb begin
    rot = {req, req} >> ptr;
    any = 1'b0;
    sum = '0;
    for (int k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IDW+1)'(k);
        if (sum >= NV) sum = sum - NV;
      end
    end
    idx = sum[IDW-1:0];
  end

  always_comb begin
    grant = '0;
    for (int j = 0; j < N; j++) grant[j] = any && (idx == IDW'(j));
  end

endmodule

// File: rtl/div_rr_scheduler.sv
// Shares one sequential divider among N requesters with round-robin grants,
// local divide-by-zero handling and a watchdog against a hung divider.
module div_rr_scheduler
  import div_rr_scheduler_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2,
  parameter int TMO = 64,
  parameter int TW  = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] dvnd_in,
  input  logic [N*W-1:0] dvsr_in,
  output logic [N-1:0]   gnt,
  output logic           rsp_valid,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_quo,
  output logic [W-1:0]   rsp_rem,
  output logic [1:0]     rsp_err,
  output logic           busy,
  output logic           div_start,
  output logic [W-1:0]   div_dvnd,
  output logic [W-1:0]   div_dvsr,
  output logic           div_clr,
  input  logic           div_ready,
  input  logic           div_done,
  input  logic [W-1:0]   div_quo,
  input  logic [W-1:0]   div_rem
);

  state_e         state;
  logic [IDW-1:0] ptr;
  logic           started;
  logic [TW-1:0]  wd;

  logic [N-1:0]   arb_gnt;
  logic [IDW-1:0] arb_idx;
  logic           arb_any;
  logic [W-1:0]   sel_dvnd;
  logic [W-1:0]   sel_dvsr;

  function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] id);
    return (int'(id) == N - 1) ? '0 : id + 1'b1;
  endfunction

  rr_arbiter_n #(.N(N), .IDW(IDW)) u_arb (
    .req  (req),
    .ptr  (ptr),
    .grant(arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

  always_comb begin
    sel_dvnd = '0;
    sel_dvsr = '0;
    for (int i = 0; i < N; i++) begin
      if (arb_gnt[i]) begin
        sel_dvnd = dvnd_in[i*W +: W];
        sel_dvsr = dvsr_in[i*W +: W];
      end
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      started   <= 1'b0;
      wd        <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_quo   <= '0;
      rsp_rem   <= '0;
      rsp_err   <= ERR_OK;
      div_start <= 1'b0;
      div_dvnd  <= '0;
      div_dvsr  <= '0;
      div_clr   <= 1'b0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      div_start <= 1'b0;
      div_clr   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            gnt      <= arb_gnt;
            rsp_id   <= arb_idx;
            div_dvnd <= sel_dvnd;
            div_dvsr <= sel_dvsr;
            started  <= 1'b0;
            if (sel_dvsr == '0) begin
              rsp_quo <= '1;
              rsp_rem <= sel_dvnd;
              rsp_err <= ERR_DZ;
              state   <= RESP;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (div_ready) begin
            div_start <= 1'b1;
            started   <= 1'b1;
            wd        <= '0;
            state     <= BUSY;
          end
        end
        // Response is presented the cycle after done/timeout; RESP then only re-arms.
        BUSY: begin
          if (div_done) begin
            rsp_quo   <= div_quo;
            rsp_rem   <= div_rem;
            rsp_err   <= ERR_OK;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (wd == TW'(TMO - 1)) begin
            rsp_quo   <= '0;
            rsp_rem   <= '0;
            rsp_err   <= ERR_TMO;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        // Divide-by-zero never visited BUSY, so its response pulse is issued here.
        RESP: begin
          rsp_valid <= !started;
          ptr       <= rr_next(rsp_id);
          if (started) begin
            div_clr <= 1'b1;
            state   <= CLEAR;
          end else begin
            state <= IDLE;
          end
        end
        CLEAR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_rr_scheduler.sv
// Bench for div_rr_scheduler: behavioural divider, directed scenarios and
// randomized traffic checked against a round-robin reference model.
module tb_div_rr_scheduler;
  localparam int N = 4, W = 8, IDW = 2, TMO = 64, TW = 8;

  logic           clk = 0, reset = 1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dvnd_in = '0, dvsr_in = '0;
  logic [N-1:0]   gnt;
  logic           rsp_valid, busy, div_start, div_clr, div_ready, div_done;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_quo, rsp_rem, div_dvnd, div_dvsr, div_quo, div_rem;
  logic [1:0]     rsp_err;

  int errors = 0, checks = 0;

  div_rr_scheduler #(.N(N), .W(W), .IDW(IDW), .TMO(TMO), .TW(TW)) dut (
    .clk(clk), .reset(reset), .req(req), .dvnd_in(dvnd_in), .dvsr_in(dvsr_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quo(rsp_quo),
    .rsp_rem(rsp_rem), .rsp_err(rsp_err), .busy(busy), .div_start(div_start),
    .div_dvnd(div_dvnd), .div_dvsr(div_dvsr), .div_clr(div_clr),
    .div_ready(div_ready), .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural divider with random latency; stub mode never finishes.
  bit stub = 0, rdy_en = 1;
  logic dv_rst, drun, ddone;
  int dcnt;
  logic [W-1:0] dq, dr;
  assign dv_rst = reset | div_clr;
  always @(posedge clk or posedge dv_rst) begin
    if (dv_rst) begin
      drun <= 0; ddone <= 0; dcnt <= 0; dq <= '0; dr <= '0;
    end else if (!drun && !ddone) begin
      if (div_start) begin
        drun <= 1; dcnt <= $urandom_range(0, W + 2);
        dq <= div_dvnd / div_dvsr; dr <= div_dvnd % div_dvsr;
      end
    end else if (drun && !stub) begin
      if (dcnt == 0) begin drun <= 0; ddone <= 1; end
      else dcnt <= dcnt - 1;
    end
  end
  assign div_ready = !drun && !ddone && rdy_en;
  assign div_done  = ddone;
  assign div_quo   = ddone ? dq : '0;
  assign div_rem   = ddone ? dr : '0;

  // Reference model
  int cyc = 0;
  logic [N-1:0]   req_s;
  logic [N*W-1:0] dvnd_s, dvsr_s;
  always @(posedge clk) begin
    cyc++;
    req_s = req; dvnd_s = dvnd_in; dvsr_s = dvsr_in;
  end

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  function automatic int onehot_id(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  int mptr = 0, exp_id = 0, gnt_cyc = 0, start_cyc = 0;
  bit pending = 0, exp_dz = 0;
  logic [W-1:0] exp_q, exp_r;
  logic [1:0]   exp_e;
  int waits [N];

  always @(negedge clk) begin
    if (reset) begin
      pending = 0; mptr = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) if (!req_s[i]) waits[i] = 0;
      if (gnt != 0 || rsp_valid || div_start)
        chk("exclusive", int'(gnt != 0) + int'(rsp_valid) + int'(div_start), 1);
      if (gnt != 0) begin
        int w;
        logic [W-1:0] a, b;
        chk("gnt_while_idle", pending, 0);
        w = rr_pick(req_s, mptr);
        chk("gnt_winner", gnt, (w < 0) ? 0 : (1 << w));
        if (w < 0) w = onehot_id(gnt);
        chk("fairness", waits[w] <= N - 1, 1);
        for (int i = 0; i < N; i++) if (req_s[i] && i != w) waits[i]++;
        waits[w] = 0;
        a = dvnd_s[w*W +: W]; b = dvsr_s[w*W +: W];
        exp_id = w; exp_dz = (b == 0);
        if (b == 0)    begin exp_q = '1;    exp_r = a;     exp_e = 2'b01; end
        else if (stub) begin exp_q = '0;    exp_r = '0;    exp_e = 2'b10; end
        else           begin exp_q = a / b; exp_r = a % b; exp_e = 2'b00; end
        pending = 1; gnt_cyc = cyc;
      end
      if (div_start) begin
        chk("start_needed", pending && !exp_dz, 1);
        start_cyc = cyc;
      end
      if (rsp_valid) begin
        chk("rsp_expected", pending, 1);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_quo", rsp_quo, exp_q);
        chk("rsp_rem", rsp_rem, exp_r);
        chk("rsp_err", rsp_err, exp_e);
        if (exp_dz) chk("dz_latency", cyc - gnt_cyc, 1);
        else if (stub) chk("tmo_latency", cyc - start_cyc, TMO);
        mptr = (exp_id + 1) % N;
        pending = 0;
      end
      if (pending && cyc - gnt_cyc > 300) begin
        chk("rsp_timeout", cyc - gnt_cyc, 300);
        pending = 0;
      end
    end
  end

  // Directed helpers: inputs change 1 time unit after the rising edge.
  task automatic step(); @(posedge clk); #1; endtask

  task automatic do_reset();
    reset = 1; req = '0; step(); step(); reset = 0; step();
  endtask

  task automatic wait_for(input int kind, input int maxc, output int n);
    bit hit;
    n = 0; hit = 0;
    while (!hit && n < maxc) begin
      step(); n++;
      case (kind)
        0: hit = (gnt != 0);
        1: hit = rsp_valid;
        default: hit = div_start;
      endcase
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    dvnd_in[i*W +: W] = a; dvsr_in[i*W +: W] = b;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, ng, nr, saw, nresp;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    step(); step();
    chk("reset_outs", {gnt, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err, busy,
                       div_start, div_dvnd, div_dvsr, div_clr}, 0);
    reset = 0; step();

    // 1: single request
    set_ops(0, 200, 7); req = 4'b0001;
    wait_for(0, 20, n); chk("t1_gnt", gnt, 4'b0001); req = '0;
    wait_for(1, 100, n);
    chk("t1_valid", rsp_valid, 1); chk("t1_quo", rsp_quo, 28);
    chk("t1_rem", rsp_rem, 4); chk("t1_err", rsp_err, 0); chk("t1_id", rsp_id, 0);

    // 2: all four requesting with identical operands
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, 9, 2);
    for (int k = 0; k < 5; k++) order[k] = -1;
    req = 4'b1111; ng = 0; nr = 0;
    for (int c = 0; c < 600 && nr < 5; c++) begin
      step();
      if (gnt != 0 && ng < 5) begin order[ng] = onehot_id(gnt); ng++; end
      if (rsp_valid) begin
        chk("t2_quo", rsp_quo, 4); chk("t2_rem", rsp_rem, 1);
        chk("t2_id", rsp_id, order[(nr < ng) ? nr : 0]);
        nr++;
      end
    end
    req = '0;
    chk("t2_count", nr, 5);
    for (int k = 0; k < 5; k++) chk("t2_order", order[k], exp_order[k]);

    // 3: divide by zero
    do_reset();
    set_ops(2, 55, 0); req = 4'b0100;
    wait_for(0, 20, n); chk("t3_gnt", gnt, 4'b0100); req = '0;
    saw = int'(div_start);
    step(); saw += int'(div_start);
    chk("t3_valid", rsp_valid, 1); chk("t3_quo", rsp_quo, 8'hFF);
    chk("t3_rem", rsp_rem, 55); chk("t3_err", rsp_err, 1); chk("t3_id", rsp_id, 2);
    for (int c = 0; c < 4; c++) begin step(); saw += int'(div_start); end
    chk("t3_no_start", saw, 0);

    // 4: hung divider, watchdog abort
    do_reset();
    stub = 1; set_ops(1, 10, 3); req = 4'b0010;
    wait_for(0, 20, n); req = '0;
    wait_for(2, 20, n); chk("t4_start", div_start, 1);
    wait_for(1, 200, n);
    chk("t4_tmo_cycles", n, TMO); chk("t4_err", rsp_err, 2);
    chk("t4_quo", rsp_quo, 0); chk("t4_rem", rsp_rem, 0);
    step(); chk("t4_clr", div_clr, 1);
    step(); chk("t4_idle", busy, 0);
    stub = 0;

    // 5: reset in BUSY
    do_reset();
    stub = 1; set_ops(0, 20, 3); req = 4'b0001;
    wait_for(0, 20, n); req = '0;
    wait_for(2, 20, n); step(); step(); step();
    chk("t5_busy_before", busy, 1);
    reset = 1; #1;
    chk("t5_reset_outs", {gnt, rsp_valid, rsp_id, rsp_quo, rsp_rem, rsp_err, busy,
                          div_start, div_dvnd, div_dvsr, div_clr}, 0);
    step(); reset = 0; stub = 0;
    saw = 0;
    for (int c = 0; c < 5; c++) begin step(); saw += int'(rsp_valid); end
    chk("t5_no_rsp", saw, 0);
    set_ops(3, 100, 9); req = 4'b1000;
    wait_for(0, 20, n); chk("t5_gnt", gnt, 4'b1000); req = '0;
    wait_for(1, 100, n);
    chk("t5_quo", rsp_quo, 11); chk("t5_rem", rsp_rem, 1); chk("t5_id", rsp_id, 3);

    // 6: random traffic
    do_reset();
    nresp = 0;
    for (int c = 0; c < 40000 && nresp < 1000; c++) begin
      step();
      if (rsp_valid) nresp++;
      for (int i = 0; i < N; i++) begin
        if (gnt[i] || !req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            set_ops(i, W'($urandom),
                    ($urandom_range(0, 19) == 0) ? '0 : W'($urandom_range(1, 255)));
          end else begin
            req[i] = 1'b0;
          end
        end else if ($urandom_range(0, 99) == 0) begin
          req[i] = 1'b0;
        end
      end
      rdy_en = ($urandom_range(0, 9) != 0);
    end
    req = '0; rdy_en = 1;
    chk("t6_count", nresp, 1000);
    for (int c = 0; c < 100; c++) step();
    chk("t6_drained", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
